acq_sequencer: RTL and testbench

- Controller that sequences one capture through the acquisition BRAM buffer. The buffer takes 12-bit samples on the write side and returns 48-bit words (4 samples each) on the read side.
- Generates the buffer's begin_acq enable and its wr_clk/rd_clk strobes, paces sample writes from a clock divider, grants UART-side read requests, and tracks buffer occupancy in samples.
- Sits between the top-level command logic, the acquisition buffer and the UART transmit path.

---
 rtl/acq_sequencer.sv | 164 ++++++++++++++++
 tb/tb_acq_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_sequencer.sv
// acq_sequencer: sequences one capture through the acquisition BRAM buffer.
// Optional macro ACQ_TRIGGER_EN holds ARM until a synchronized trig is seen.
module acq_sequencer #(
  parameter int unsigned ACQ_DEPTH  = 11,
  parameter int unsigned N_SAMPLES  = 1024,
  parameter int unsigned SAMPLE_DIV = 16,
  parameter int unsigned DATA_LAT   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               trig,
  input  logic               rd_req,
  output logic               begin_acq,
  output logic               wr_clk,
  output logic               rd_clk,
  output logic               rd_ack,
  output logic               rd_valid,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [ACQ_DEPTH:0] level
);
  localparam int unsigned LVL_W = ACQ_DEPTH + 1;
  localparam int unsigned CNT_W = $clog2(N_SAMPLES + 1);
  localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);

  localparam logic [LVL_W-1:0] LVL_CAP   = {1'b1, {ACQ_DEPTH{1'b0}}};
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_THREE = LVL_W'(3);
  localparam logic [LVL_W-1:0] LVL_FOUR  = LVL_W'(4);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(N_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);

  typedef enum logic [1:0] {IDLE, ARM, FILL, DRAIN} state_t;
  state_t state, state_nx;

  logic [CNT_W-1:0]    written;
  logic [DIV_W-1:0]    div_cnt;
  logic [DATA_LAT-1:0] valid_pipe;
  logic [LVL_W-1:0]    level_nx;
  logic settled, wr_first, rd_low_prev, trig_ok, done_nx;
  logic start_ok, sample_tick, wr_fire, rd_accept;

`ifdef ACQ_TRIGGER_EN
  logic trig_s1, trig_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
    end else begin
      trig_s1 <= trig;
      trig_s2 <= trig_s1;
    end
  end

  assign trig_ok = trig_s2;
`else
  logic unused_trig;
  assign unused_trig = trig;
  assign trig_ok     = 1'b1;
`endif

  assign begin_acq = (state != IDLE);
  assign busy      = (state != IDLE);
  assign rd_valid  = valid_pipe[DATA_LAT-1];

  // settled keeps start out for one IDLE cycle so begin_acq stays low >= 2 cycles
  always_comb begin
    start_ok    = (state == IDLE) && start && settled && !abort;
    sample_tick = (state == FILL) && (div_cnt == DIV_LAST) && (written != CNT_LAST);
    wr_fire     = sample_tick && (level != LVL_CAP);
    rd_accept   = (state != IDLE) && rd_req && !rd_clk && rd_low_prev &&
                  (level >= LVL_FOUR) && !abort;
    case ({wr_fire, rd_accept})
      2'b10:   level_nx = level + LVL_ONE;
      2'b01:   level_nx = level - LVL_FOUR;
      2'b11:   level_nx = level - LVL_THREE;
      default: level_nx = level;
    endcase
  end

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:  if (start_ok) state_nx = ARM;
        ARM:   if (trig_ok) state_nx = FILL;
        FILL:  if (written == CNT_LAST) state_nx = DRAIN;
        DRAIN: begin
          if (level < LVL_FOUR) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      done        <= 1'b0;
      settled     <= 1'b0;
      rd_low_prev <= 1'b0;
      level       <= '0;
      written     <= '0;
      div_cnt     <= '0;
      wr_clk      <= 1'b0;
      wr_first    <= 1'b0;
      rd_clk      <= 1'b0;
      rd_ack      <= 1'b0;
      valid_pipe  <= '0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nx;
      done        <= done_nx;
      settled     <= (state == IDLE);
      rd_low_prev <= !rd_clk;
      if (abort) begin
        level      <= '0;
        written    <= '0;
        div_cnt    <= '0;
        wr_clk     <= 1'b0;
        wr_first   <= 1'b0;
        rd_clk     <= 1'b0;
        rd_ack     <= 1'b0;
        valid_pipe <= '0;
      end else begin
        // Strobes stay high for the rise cycle plus one more
        wr_clk        <= wr_fire | (wr_clk & wr_first);
        wr_first      <= wr_fire;
        rd_clk        <= rd_accept | (rd_clk & rd_ack);
        rd_ack        <= rd_accept;
        valid_pipe[0] <= rd_ack;
        for (int unsigned i = 1; i < DATA_LAT; i++) begin
          valid_pipe[i] <= valid_pipe[i-1];
        end
        if (start_ok) begin
          level   <= '0;
          written <= '0;
        end else begin
          level <= level_nx;
          if (sample_tick) written <= written + CNT_ONE;
        end
        div_cnt <= ((state == FILL) && (div_cnt != DIV_LAST)) ? div_cnt + DIV_ONE : '0;
      end
      if (start_ok) begin
        overflow <= 1'b0;
      end else if (sample_tick && !wr_fire && !abort) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer: u0 (N=8, DIV=8) and u1 (CAP=8, N=12, DIV=8).
module tb_acq_sequencer;
  logic clk = 1'b0;
  logic rst_n;

  logic start0, abort0, trig0, rd_req0;
  logic begin_acq0, wr_clk0, rd_clk0, rd_ack0, rd_valid0, busy0, done0, overflow0;
  logic [11:0] level0;

  logic start1, abort1, trig1, rd_req1;
  logic begin_acq1, wr_clk1, rd_clk1, rd_ack1, rd_valid1, busy1, done1, overflow1;
  logic [3:0] level1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  acq_sequencer #(.ACQ_DEPTH(11), .N_SAMPLES(8), .SAMPLE_DIV(8), .DATA_LAT(3)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .trig(trig0), .rd_req(rd_req0),
    .begin_acq(begin_acq0), .wr_clk(wr_clk0), .rd_clk(rd_clk0), .rd_ack(rd_ack0),
    .rd_valid(rd_valid0), .busy(busy0), .done(done0), .overflow(overflow0), .level(level0)
  );

  acq_sequencer #(.ACQ_DEPTH(3), .N_SAMPLES(12), .SAMPLE_DIV(8), .DATA_LAT(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .trig(trig1), .rd_req(rd_req1),
    .begin_acq(begin_acq1), .wr_clk(wr_clk1), .rd_clk(rd_clk1), .rd_ack(rd_ack1),
    .rd_valid(rd_valid1), .busy(busy1), .done(done1), .overflow(overflow1), .level(level1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start0 = 1'b0; abort0 = 1'b0; trig0 = 1'b1; rd_req0 = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; trig1 = 1'b1; rd_req1 = 1'b0;
    tick; tick;
    n_assert++;
    if ({begin_acq0, wr_clk0, rd_clk0, rd_ack0, rd_valid0, busy0, done0, overflow0} !== 8'b0 ||
        level0 !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_u0: outputs=%b level=%0d, required 00000000 level=0",
               {begin_acq0, wr_clk0, rd_clk0, rd_ack0, rd_valid0, busy0, done0, overflow0}, level0);
    end
    n_assert++;
    if ({begin_acq1, wr_clk1, rd_clk1, rd_ack1, rd_valid1, busy1, done1, overflow1} !== 8'b0 ||
        level1 !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_u1: outputs=%b level=%0d, required 00000000 level=0",
               {begin_acq1, wr_clk1, rd_clk1, rd_ack1, rd_valid1, busy1, done1, overflow1}, level1);
    end
    rst_n = 1'b1;
    tick; tick; tick;
    n_assert++;
    if ({begin_acq0, wr_clk0, rd_clk0, busy0, done0} !== 5'b0 || level0 !== 12'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: outputs=%b level=%0d, required 00000 level=0",
               {begin_acq0, wr_clk0, rd_clk0, busy0, done0}, level0);
    end
  endtask

  task automatic test_basic;
    logic [7:0]  exp_v, got_v;
    logic [11:0] exp_lvl;
    int unsigned w, r;
    start0 = 1'b1; tick; start0 = 1'b0;
    n_assert++;
    if (busy0 !== 1'b1 || begin_acq0 !== 1'b1 || wr_clk0 !== 1'b0 || level0 !== 12'd0) begin
      n_fail++;
      $display("FAIL arm_entry: busy=%b begin_acq=%b wr_clk=%b level=%0d, required 1 1 0 0",
               busy0, begin_acq0, wr_clk0, level0);
    end
    tick;
    for (int k = 0; k <= 70; k++) begin
      if (k > 0) tick;
      rd_req0 = (k == 32 || k == 64);
      start0  = (k == 66);
      w = (k / 8 > 8) ? 8 : k / 8;
      r = ((k >= 33) ? 1 : 0) + ((k >= 65) ? 1 : 0);
      exp_lvl = 12'(w - 4 * r);
      exp_v = {(k >= 8 && k <= 65 && (k % 8) < 2),
               (k == 33 || k == 34 || k == 65 || k == 66),
               (k == 33 || k == 65),
               (k == 36 || k == 68),
               (k < 66), (k < 66), (k == 66), 1'b0};
      got_v = {wr_clk0, rd_clk0, rd_ack0, rd_valid0, busy0, begin_acq0, done0, overflow0};
      n_assert++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL basic_strobes k=%0d: {wr,rd,ack,valid,busy,begin,done,ovf}=%b, required %b",
                 k, got_v, exp_v);
      end
      n_assert++;
      if (level0 !== exp_lvl) begin
        n_fail++;
        $display("FAIL basic_level k=%0d: level=%0d, required %0d", k, level0, exp_lvl);
      end
    end
    tick; tick;
  endtask

  task automatic test_underflow;
    start0 = 1'b1; tick; start0 = 1'b0; tick;
    for (int k = 0; k <= 26; k++) begin
      if (k > 0) tick;
      rd_req0 = (k == 24);
      if (k == 24) begin
        n_assert++;
        if (level0 !== 12'd3) begin
          n_fail++;
          $display("FAIL underflow_setup: level=%0d, required 3", level0);
        end
      end
      if (k == 25) begin
        n_assert++;
        if (rd_ack0 !== 1'b0 || rd_clk0 !== 1'b0 || level0 !== 12'd3) begin
          n_fail++;
          $display("FAIL underflow_guard: rd_ack=%b rd_clk=%b level=%0d, required 0 0 3",
                   rd_ack0, rd_clk0, level0);
        end
      end
    end
    abort0 = 1'b1; tick; abort0 = 1'b0;
    tick; tick;
  endtask

  task automatic test_simultaneous;
    start0 = 1'b1; tick; start0 = 1'b0; tick;
    for (int k = 0; k <= 68; k++) begin
      if (k > 0) tick;
      rd_req0 = (k == 47 || k == 64);
      if (k == 47) begin
        n_assert++;
        if (level0 !== 12'd5 || rd_clk0 !== 1'b0) begin
          n_fail++;
          $display("FAIL simul_setup: level=%0d rd_clk=%b, required 5 0", level0, rd_clk0);
        end
      end
      if (k == 48) begin
        n_assert++;
        if (level0 !== 12'd2 || {wr_clk0, rd_clk0, rd_ack0} !== 3'b111) begin
          n_fail++;
          $display("FAIL simul_level: level=%0d {wr,rd,ack}=%b, required 2 111",
                   level0, {wr_clk0, rd_clk0, rd_ack0});
        end
      end
      if (k == 66) begin
        n_assert++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || level0 !== 12'd0) begin
          n_fail++;
          $display("FAIL simul_done: done=%b busy=%b level=%0d, required 1 0 0",
                   done0, busy0, level0);
        end
      end
    end
    tick; tick;
  endtask

  task automatic test_abort;
    start0 = 1'b1; tick; start0 = 1'b0; tick;
    for (int k = 1; k <= 40; k++) tick;
    n_assert++;
    if (level0 !== 12'd5 || wr_clk0 !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_setup: level=%0d wr_clk=%b, required 5 1", level0, wr_clk0);
    end
    abort0 = 1'b1; tick; abort0 = 1'b0;
    n_assert++;
    if ({busy0, begin_acq0, wr_clk0, rd_clk0, done0} !== 5'b0 || level0 !== 12'd0) begin
      n_fail++;
      $display("FAIL abort_idle: {busy,begin,wr,rd,done}=%b level=%0d, required 00000 0",
               {busy0, begin_acq0, wr_clk0, rd_clk0, done0}, level0);
    end
    for (int k = 0; k < 4; k++) begin
      tick;
      n_assert++;
      if ({busy0, wr_clk0, done0} !== 3'b0) begin
        n_fail++;
        $display("FAIL abort_quiet c=%0d: {busy,wr,done}=%b, required 000",
                 k, {busy0, wr_clk0, done0});
      end
    end
  endtask

  task automatic test_overflow;
    logic [3:0] exp_v, got_v;
    logic [3:0] exp_lvl;
    start1 = 1'b1; tick; start1 = 1'b0; tick;
    for (int k = 0; k <= 110; k++) begin
      if (k > 0) tick;
      rd_req1 = (k == 100);
      exp_lvl = (k >= 101) ? 4'd4 : ((k / 8 > 8) ? 4'd8 : 4'(k / 8));
      exp_v = {(k >= 8 && k <= 65 && (k % 8) < 2), (k == 101 || k == 102), 1'b1, (k >= 72)};
      got_v = {wr_clk1, rd_clk1, busy1, overflow1};
      n_assert++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL ovf_strobes k=%0d: {wr,rd,busy,ovf}=%b, required %b", k, got_v, exp_v);
      end
      n_assert++;
      if (level1 !== exp_lvl) begin
        n_fail++;
        $display("FAIL ovf_level k=%0d: level=%0d, required %0d", k, level1, exp_lvl);
      end
    end
    abort1 = 1'b1; tick; abort1 = 1'b0;
    n_assert++;
    if ({busy1, done1, overflow1} !== 3'b001 || level1 !== 4'd0) begin
      n_fail++;
      $display("FAIL ovf_abort: {busy,done,ovf}=%b level=%0d, required 001 0",
               {busy1, done1, overflow1}, level1);
    end
    tick; tick;
    n_assert++;
    if (overflow1 !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: overflow=%b, required 1", overflow1);
    end
    start1 = 1'b1; tick; start1 = 1'b0;
    n_assert++;
    if (overflow1 !== 1'b0 || busy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_start_clear: overflow=%b busy=%b, required 0 1", overflow1, busy1);
    end
    abort1 = 1'b1; tick; abort1 = 1'b0;
    tick; tick;
  endtask

`ifdef ACQ_TRIGGER_EN
  task automatic test_trigger;
    logic exp_wr;
    trig0 = 1'b0; tick; tick; tick;
    start0 = 1'b1; tick; start0 = 1'b0;
    for (int t = 0; t <= 31; t++) begin
      if (t > 0) tick;
      if (t == 19) trig0 = 1'b1;
      exp_wr = (t == 30 || t == 31);
      n_assert++;
      if (wr_clk0 !== exp_wr || busy0 !== 1'b1) begin
        n_fail++;
        $display("FAIL trigger t=%0d: wr_clk=%b busy=%b, required %b 1", t, wr_clk0, busy0, exp_wr);
      end
    end
    abort0 = 1'b1; tick; abort0 = 1'b0;
    tick; tick;
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_underflow;
    test_simultaneous;
    test_abort;
    test_overflow;
`ifdef ACQ_TRIGGER_EN
    test_trigger;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
